// File: rtl/sad_pkg.sv
// sad_pkg: shared FSM state encoding, default widths and the all-ones SAD seed for the SAD search scheduler
package sad_pkg;
  localparam int SAD_W = 32;
  localparam int A_WIDTH = 15;
  localparam logic [SAD_W-1:0] SAD_MAX = '1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FIN} state_t;
endpackage

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: running-minimum register (Clk, Rst, init seeds all-ones/idx 0, en+Sad/Idx strict-less compare, Best_Idx/Best_Sad out)
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int SAD_W = sad_pkg::SAD_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             init,
  input  logic             en,
  input  logic [SAD_W-1:0] sad,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] Best_Idx,
  output logic [SAD_W-1:0] Best_Sad
);
  always_ff @(posedge Clk)
    if (Rst) begin
      Best_Idx <= '0;
      Best_Sad <= '0;
    end else if (init) begin
      Best_Idx <= '0;
      Best_Sad <= {SAD_W{SAD_MAX[0]}};
    end else if (en && sad < Best_Sad) begin
      Best_Idx <= idx;
      Best_Sad <= sad;
    end
endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: SAD candidate scheduler (Clk/Rst, Start->Busy/Done/Best_Idx/Best_Sad, Sad_Go/Cand_Base/Sad_Valid/Sad_In engine side; SAD_SEARCH_EARLY_EXIT_EN stops on a zero SAD)
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int NUM_CAND    = 16,
  parameter int IDX_W       = 8,
  parameter int A_WIDTH     = sad_pkg::A_WIDTH,
  parameter int CAND_STRIDE = 256,
  parameter int SAD_W       = sad_pkg::SAD_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  output logic [IDX_W-1:0]   Best_Idx,
  output logic [SAD_W-1:0]   Best_Sad,
  output logic               Sad_Go,
  output logic [A_WIDTH-1:0] Cand_Base,
  input  logic               Sad_Valid,
  input  logic [SAD_W-1:0]   Sad_In
);
  localparam logic [A_WIDTH-1:0] STEP = A_WIDTH'(CAND_STRIDE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic last;
  logic capture;
  assign capture = state == WAIT && Sad_Valid;
`ifdef SAD_SEARCH_EARLY_EXIT_EN
  logic zero_seen;
  always_ff @(posedge Clk)
    if (Rst || state == IDLE) zero_seen <= 1'b0;
    else if (capture && Sad_In == '0) zero_seen <= 1'b1;
  assign last = zero_seen || idx == LAST_IDX;
`else
  assign last = idx == LAST_IDX;
`endif
  always_ff @(posedge Clk)
    if (Rst) begin
      state     <= IDLE;
      idx       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Sad_Go    <= 1'b0;
      Cand_Base <= '0;
    end else begin
      Sad_Go <= 1'b0;
      Done   <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          idx       <= '0;
          Cand_Base <= '0;
          Sad_Go    <= 1'b1;
          Busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (Sad_Valid) state <= NEXT;
        NEXT: if (last) begin
          Done  <= 1'b1;
          state <= FIN;
        end else begin
          idx       <= idx + 1'b1;
          Cand_Base <= Cand_Base + STEP;
          Sad_Go    <= 1'b1;
          state     <= ISSUE;
        end
        FIN: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  sad_min_tracker #(.IDX_W(IDX_W), .SAD_W(SAD_W)) u_min (
    .Clk(Clk),
    .Rst(Rst),
    .init(state == IDLE && Start),
    .en(capture),
    .sad(Sad_In),
    .idx(idx),
    .Best_Idx(Best_Idx),
    .Best_Sad(Best_Sad)
  );
endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl: randomized scoreboard bench for sad_search_ctrl against a list-based best-match model
module tb_sad_search_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int pass_n = 0;
  int chk_n = 0;
  logic start_s[2];
  logic busy[2], done[2], go[2];
  logic [7:0] bidx[2];
  logic [31:0] bsad[2];
  logic [14:0] base[2];
  logic spur_v;
  logic [31:0] spur_sad;
  int lat_cfg[2];
  int eng_q[2][$];
  int exp_base[2][$];
  int exp_idx[2][$];
  int exp_sad[2][$];

  task automatic chk(input string name, input longint act, input longint exp);
    chk_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int NC = g == 0 ? 4 : 6;
    localparam int ST = g == 0 ? 256 : 8192;
    logic eng_v;
    logic [31:0] eng_sad;
    logic sv;
    logic [31:0] sin;
    assign sv = eng_v | (g == 0 ? spur_v : 1'b0);
    assign sin = (g == 0 && spur_v) ? spur_sad : eng_sad;
    sad_search_ctrl #(.NUM_CAND(NC), .IDX_W(8), .A_WIDTH(15), .CAND_STRIDE(ST), .SAD_W(32)) dut (
      .Clk(clk), .Rst(rst), .Start(start_s[g]), .Busy(busy[g]), .Done(done[g]),
      .Best_Idx(bidx[g]), .Best_Sad(bsad[g]), .Sad_Go(go[g]), .Cand_Base(base[g]),
      .Sad_Valid(sv), .Sad_In(sin)
    );
    // engine: samples Go at the edge ending ISSUE, result appears L cycles later
    initial begin
      int v;
      eng_v = 1'b0;
      eng_sad = '0;
      forever begin
        @(negedge clk);
        if (go[g] === 1'b1) begin
          v = eng_q[g].size() > 0 ? eng_q[g].pop_front() : int'($urandom_range(1, 99));
          repeat (lat_cfg[g] + 1) @(posedge clk);
          #1 eng_v = 1'b1;
          eng_sad = v;
          @(posedge clk);
          #1 eng_v = 1'b0;
        end
      end
    end
    always @(negedge clk) begin
      if (go[g] === 1'b1) begin
        if (exp_base[g].size() == 0) begin
          chk_n++;
          $display("FAIL unexpected_go%0d: Sad_Go with Cand_Base %0d, required no Sad_Go", g, base[g]);
        end else begin
          chk($sformatf("cand_base%0d", g), base[g], exp_base[g].pop_front());
          chk($sformatf("busy_at_go%0d", g), busy[g], 1);
        end
      end
      if (done[g] === 1'b1) begin
        if (exp_idx[g].size() == 0) begin
          chk_n++;
          $display("FAIL unexpected_done%0d: Done pulse, required none", g);
        end else begin
          chk($sformatf("best_idx%0d", g), bidx[g], exp_idx[g].pop_front());
          chk($sformatf("best_sad%0d", g), bsad[g], exp_sad[g].pop_front());
          chk($sformatf("busy_at_done%0d", g), busy[g], 1);
        end
      end
    end
  end

  task automatic search(input int g, input int nc, input int stride, input int v[8], input int lat,
                        output int dur, output int e_idx, output longint e_sad);
    int n;
    int c0;
    int k;
    longint b;
    int bi;
    n = nc;
    b = 64'hFFFF_FFFF;
    bi = 0;
`ifdef SAD_SEARCH_EARLY_EXIT_EN
    for (int i = 0; i < nc; i++)
      if (v[i] == 0) begin
        n = i + 1;
        break;
      end
`endif
    for (int i = 0; i < n; i++)
      if (v[i] < b) begin
        b = v[i];
        bi = i;
      end
    eng_q[g].delete();
    for (int i = 0; i < nc; i++) eng_q[g].push_back(v[i]);
    for (int i = 0; i < n; i++) exp_base[g].push_back((i * stride) % 32768);
    exp_idx[g].push_back(bi);
    exp_sad[g].push_back(int'(b));
    e_idx = bi;
    e_sad = b;
    lat_cfg[g] = lat;
    @(posedge clk);
    #1 start_s[g] = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 start_s[g] = 1'b0;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done[g] === 1'b1) break;
    end
    if (k == 1000) begin
      chk_n++;
      $display("FAIL timeout%0d: no Done within 1000 cycles, required Done", g);
      dur = -1;
    end else dur = cyc - c0;
    @(negedge clk);
    chk($sformatf("busy_after_done%0d", g), busy[g], 0);
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_busy%0d", tag, g), busy[g], 0);
      chk($sformatf("%s_done%0d", tag, g), done[g], 0);
      chk($sformatf("%s_go%0d", tag, g), go[g], 0);
      chk($sformatf("%s_base%0d", tag, g), base[g], 0);
      chk($sformatf("%s_bidx%0d", tag, g), bidx[g], 0);
      chk($sformatf("%s_bsad%0d", tag, g), bsad[g], 0);
    end
  endtask

  initial begin
    int dur, ei, k;
    longint es;
    int v[8];
    rst = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    spur_v = 1'b0;
    spur_sad = '0;
    lat_cfg[0] = 3;
    lat_cfg[1] = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    // directed L=3 run with a tie on SAD 20
    search(0, 4, 256, '{50, 20, 35, 20, 0, 0, 0, 0}, 3, dur, ei, es);
    chk("duration", dur, 25);
    // spurious Sad_Valid in ISSUE and a mid-search Start must change nothing
    for (int i = 0; i < 8; i++) v[i] = $urandom_range(1, 99);
    fork
      search(0, 4, 256, v, 2, dur, ei, es);
      begin
        for (k = 0; k < 200; k++) begin
          @(negedge clk);
          if (go[0] === 1'b1) break;
        end
        spur_v = 1'b1;
        spur_sad = 0;
        @(posedge clk);
        #1 spur_v = 1'b0;
        @(posedge clk);
        #1 start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
      end
    join
    @(posedge clk);
    #1 spur_v = 1'b1;
    @(posedge clk);
    #1 spur_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_spur_idx", bidx[0], ei);
    chk("idle_spur_sad", bsad[0], es);
    // reset during WAIT of candidate 2, engine result lands one cycle into IDLE
    eng_q[0].delete();
    eng_q[0].push_back(30);
    eng_q[0].push_back(10);
    eng_q[0].push_back(5);
    for (int i = 0; i < 3; i++) exp_base[0].push_back(i * 256);
    lat_cfg[0] = 3;
    @(posedge clk);
    #1 start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    dur = 0;
    for (k = 0; k < 200 && dur < 3; k++) begin
      @(negedge clk);
      if (go[0] === 1'b1) dur++;
    end
    chk("reset_test_gos", dur, 3);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    repeat (10) @(negedge clk);
    chk_zero("postrst");
    chk("rst_pending_bases", exp_base[0].size(), 0);
    for (int i = 0; i < 8; i++) v[i] = $urandom_range(1, 99);
    search(0, 4, 256, v, 3, dur, ei, es);
    chk("restart_duration", dur, 25);
    // address wrap with an 8192 stride in 15 bits
    for (int i = 0; i < 8; i++) v[i] = $urandom_range(0, 50);
    search(1, 6, 8192, v, 1, dur, ei, es);
    // zero SAD mid-list (early exit when enabled)
    search(0, 4, 256, '{9, 0, 4, 4, 0, 0, 0, 0}, 2, dur, ei, es);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom_range(0, 12);
      search(0, 4, 256, v, $urandom_range(1, 4), dur, ei, es);
    end
    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("left_bases%0d", g), exp_base[g].size(), 0);
      chk($sformatf("left_results%0d", g), exp_idx[g].size(), 0);
    end
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Search scheduler that sequences the SAD engine across `NUM_CAND` candidate blocks and reports the best match. For each candidate it issues one `Go` pulse to the engine and drives that candidate's base address. It then waits for the engine's result strobe and keeps a running minimum. It sits between the host/motion-estimation top level and the SAD engine, and owns the engine's `Go` input.

## Interface
- `NUM_CAND`, 16: number of candidate blocks per search (2..256).
- `IDX_W`, 8: index width; must satisfy `NUM_CAND <= 2**IDX_W`.
- `A_WIDTH`, 15: candidate base-address width.
- `CAND_STRIDE`, 256: address distance between consecutive candidates.
- `SAD_W`, 32: SAD value width.
- `Clk  in  1`: the single clock. All logic is on its rising edge.
- `Rst  in  1`: synchronous, active-high reset.
- `Start  in  1`: host request to begin a search; sampled only in IDLE.
- `Busy  out  1`: high from the cycle after Start is accepted until Done.
- `Done  out  1`: one-cycle pulse when the search completes.
- `Best_Idx  out  IDX_W`: index of the minimum-SAD candidate.
- `Best_Sad  out  SAD_W`: minimum SAD value.
- `Sad_Go  out  1`: one-cycle start pulse to the SAD engine.
- `Cand_Base  out  A_WIDTH`: base address of the current candidate; held stable from ISSUE through WAIT.
- `Sad_Valid  in  1`: engine result strobe.
- `Sad_In  in  SAD_W`: engine result, qualified by `Sad_Valid`.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FIN.
- IDLE:
  - If `Start`=1: clear `idx` to 0, set the running best to all-ones, set the index to 0, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `Sad_Go`=1 for exactly this cycle.
  - `Cand_Base` = (`idx`·`CAND_STRIDE`) mod 2^`A_WIDTH`.
  - Go to WAIT.
- WAIT: wait for `Sad_Valid`. On `Sad_Valid`=1:
  - If `Sad_In` < current best (strict compare), load `Sad_In` and `idx` into the best registers.
  - Go to NEXT.
- NEXT:
  - If `idx` = `NUM_CAND`-1, go to FIN.
  - Otherwise increment `idx` and go to ISSUE.
- FIN: `Done`=1 for one cycle, then go to IDLE.
- Tie rule: equal SADs keep the earlier (lower) index.
- `Best_Idx`/`Best_Sad` are held after FIN until the next accepted `Start`. They update internally during a search; the host treats them as valid only at or after `Done`.
- `Start` while not in IDLE: ignored. No queuing.
- `Sad_Valid` outside WAIT: ignored. The engine's first cycle after `Go` overlaps WAIT, not ISSUE.
- Reset at any time:
  - State goes to IDLE, `idx`=0.
  - All outputs go to 0, including `Best_Sad`=0.
  - Any search in flight is abandoned; a late `Sad_Valid` is ignored because the block is in IDLE.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Sad_Go`=0, `Cand_Base`=0, `Best_Idx`=0, `Best_Sad`=0.
- Cycle 0: `Start` sampled. Cycle 1: ISSUE with `Sad_Go`=1 and `Busy`=1.
- Per-candidate cost: 3 cycles + L, where L is the engine latency from `Sad_Go` to `Sad_Valid` (L ≥ 1).
- Best registers update on the edge that samples `Sad_Valid` in WAIT.
- `Done` is asserted 2 cycles after the last `Sad_Valid` (NEXT, then FIN). `Busy` drops in the cycle after `Done`.
- All outputs are registered. There is no combinational path from `Sad_Valid`/`Sad_In` to any output.

## Configuration
- `SAD_SEARCH_EARLY_EXIT_EN` defined:
  - A captured `Sad_In` of 0 in WAIT forces NEXT to go straight to FIN, regardless of `idx`.
  - `Best_Idx` is that candidate's index.
  - No further `Sad_Go` is issued.
- Undefined: all `NUM_CAND` candidates are always scheduled.

## Structure
- Shared package `sad_pkg`:
  - state encoding enum (IDLE..FIN);
  - `SAD_W` and `A_WIDTH` defaults;
  - `SAD_MAX` all-ones constant.
- One natural sub-module, `sad_min_tracker`: holds the running best, takes the compare enable and value/index, provides an init input, outputs `Best_Idx`/`Best_Sad`.
- The FSM and address generator stay in the top module.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, no `Sad_Go`.
- `NUM_CAND`=4, engine with L=3 returning 50, 20, 35, 20:
  - exactly 4 `Sad_Go` pulses, with `Cand_Base` 0, 256, 512, 768;
  - `Done` pulse with `Best_Idx`=1, `Best_Sad`=20 (tie keeps index 1);
  - total duration 4·6+1 = 25 cycles from `Start` to `Done`.
- `Start` reasserted mid-search and spurious `Sad_Valid` during ISSUE/IDLE: no restart, no extra `Sad_Go`, result unchanged.
- `Rst` asserted during WAIT of candidate 2, engine's `Sad_Valid` arriving 1 cycle later: block in IDLE, outputs 0, no `Done`. A new `Start` then completes normally.
- `CAND_STRIDE`=8192, `A_WIDTH`=15, `NUM_CAND`=6: `Cand_Base` sequence 0, 8192, 16384, 24576, 0, 8192 (wrap).
- With `SAD_SEARCH_EARLY_EXIT_EN`, results 9, 0, 4, 4: only 2 `Sad_Go` pulses; `Done` with `Best_Idx`=1, `Best_Sad`=0.
